// File: rtl/fabric_xact_initiator.sv
// Single-outstanding fabric master.
// A command stream (op/addr/wdata/wstrb) becomes one fabric request at a time.
// Each response, or a timeout, comes back as one entry on the result stream.
// Each request carries a rolling ID. A response whose ID does not match is flagged.
// A response that arrives while no request is outstanding is dropped and counted as stale.

package carbon_arch_pkg;
    localparam int         CARBON_FABRIC_ATTR_WIDTH_BITS = 8;
    localparam logic [7:0] CARBON_FABRIC_XACT_READ       = 8'h00;
    localparam logic [7:0] CARBON_FABRIC_XACT_WRITE      = 8'h01;
    localparam logic [7:0] CARBON_FABRIC_RESP_OK         = 8'h00;
    localparam logic [7:0] CARBON_FABRIC_RESP_DECODE_ERR = 8'h02;
endpackage

// Request/response fabric port: one valid/ready request channel and one response channel.
interface fabric_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int OP_W   = 8,
    parameter int SIZE_W = 3,
    parameter int ATTR_W = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int CODE_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [OP_W-1:0]       req_op;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic [SIZE_W-1:0]     req_size;
    logic [ATTR_W-1:0]     req_attr;
    logic [ID_W-1:0]       req_id;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [CODE_W-1:0]     rsp_code;
    logic [ID_W-1:0]       rsp_id;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );
endinterface

module fabric_xact_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int OP_W           = 8,
    parameter int SIZE_W         = 3,
    parameter int ATTR_W         = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int CODE_W         = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_rdata,
    output logic [CODE_W-1:0]   res_code,
    output logic                res_id_err,
    output logic                res_timeout,
    output logic [7:0]          stale_cnt,
    fabric_if.master            bus
);
    localparam int STRB_W = DATA_W / 8;
    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_RESULT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [OP_W-1:0]     r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_next_id;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [DATA_W-1:0]   r_res_rdata;
    logic [CODE_W-1:0]   r_res_code;
    logic                r_res_id_err;
    logic                r_res_timeout;
    logic [7:0]          r_stale_cnt;

    logic w_req_valid;
    logic w_rsp_ready;
    logic w_cmd_fire;
    logic w_req_fire;
    logic w_rsp_take;
    logic w_tmo_hit;
    logic w_tmo_fire;
    logic w_stale;

    // The handshakes are decoded from the state alone, so the ready and valid outputs never feed back into them.
    assign w_cmd_fire = (r_state == S_IDLE) && cmd_valid;
    assign w_req_fire = (r_state == S_REQ) && bus.req_ready;
    assign w_rsp_take = (r_state == S_WAIT_RSP) && bus.rsp_valid;
    assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST);
    // If a response arrives in the same cycle as the timeout, the response wins.
    assign w_tmo_fire = (r_state == S_WAIT_RSP) && !bus.rsp_valid && w_tmo_hit;
    assign w_stale    = ((r_state == S_IDLE) || (r_state == S_REQ)) && bus.rsp_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the handshake outputs.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        res_valid    = 1'b0;
        w_req_valid  = 1'b0;
        w_rsp_ready  = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_state_next = S_REQ;
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                if (bus.req_ready) w_state_next = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (bus.rsp_valid || w_tmo_hit) w_state_next = S_RESULT;
            end
            S_RESULT: begin
                res_valid   = 1'b1;
                w_rsp_ready = 1'b0;
                if (res_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch the command and allocate the next rolling ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_id      <= '0;
            r_next_id <= '0;
        end else if (w_cmd_fire) begin
            r_op      <= cmd_op;
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_id      <= r_next_id;
            r_next_id <= r_next_id + ID_W'(1);
        end
    end

    // The response timer starts at the request handshake and runs only while waiting for the response.
    always_ff @(posedge clk) begin
        if (rst || w_req_fire) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT_RSP) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Capture the result: the fabric response, or zeros with the timeout flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_rdata   <= '0;
            r_res_code    <= '0;
            r_res_id_err  <= 1'b0;
            r_res_timeout <= 1'b0;
        end else if (w_rsp_take) begin
            r_res_rdata   <= bus.rsp_rdata;
            r_res_code    <= bus.rsp_code;
            r_res_id_err  <= (bus.rsp_id != r_id);
            r_res_timeout <= 1'b0;
        end else if (w_tmo_fire) begin
            r_res_rdata   <= '0;
            r_res_code    <= '0;
            r_res_id_err  <= 1'b0;
            r_res_timeout <= 1'b1;
        end
    end

    // Count responses that arrive with nothing outstanding; the count saturates at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stale_cnt <= '0;
        end else if (w_stale && (r_stale_cnt != 8'hFF)) begin
            r_stale_cnt <= r_stale_cnt + 8'd1;
        end
    end

    assign bus.req_valid = w_req_valid;
    assign bus.req_op    = r_op;
    assign bus.req_addr  = r_addr;
    assign bus.req_wdata = r_wdata;
    assign bus.req_wstrb = r_wstrb;
    assign bus.req_size  = SIZE_W'($clog2(STRB_W));
    assign bus.req_attr  = '0;
    assign bus.req_id    = r_id;
    assign bus.rsp_ready = w_rsp_ready;

    assign res_rdata   = r_res_rdata;
    assign res_code    = r_res_code;
    assign res_id_err  = r_res_id_err;
    assign res_timeout = r_res_timeout;
    assign stale_cnt   = r_stale_cnt;
endmodule

// File: tb/tb_fabric_xact_initiator.sv
// Directed bench for fabric_xact_initiator. Bench tasks play both the command source and the fabric slave.
module tb_fabric_xact_initiator;
    import carbon_arch_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int OP_W   = 8;
    localparam int SIZE_W = 3;
    localparam int ATTR_W = CARBON_FABRIC_ATTR_WIDTH_BITS;
    localparam int CODE_W = 8;
    localparam logic [7:0] RD  = CARBON_FABRIC_XACT_READ;
    localparam logic [7:0] WR  = CARBON_FABRIC_XACT_WRITE;
    localparam logic [7:0] OK  = CARBON_FABRIC_RESP_OK;
    localparam logic [7:0] DEC = CARBON_FABRIC_RESP_DECODE_ERR;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_rdata;
    logic [CODE_W-1:0] res_code;
    logic              res_id_err;
    logic              res_timeout;
    logic [7:0]        stale_cnt;

    fabric_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OP_W(OP_W),
                .SIZE_W(SIZE_W), .ATTR_W(ATTR_W), .CODE_W(CODE_W)) bus ();

    fabric_xact_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OP_W(OP_W), .SIZE_W(SIZE_W),
        .ATTR_W(ATTR_W), .CODE_W(CODE_W), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .res_valid(res_valid), .res_ready(res_ready), .res_rdata(res_rdata), .res_code(res_code),
        .res_id_err(res_id_err), .res_timeout(res_timeout), .stale_cnt(stale_cnt),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // The slave stores 64 bytes; an access at or beyond address 0x40 gets a decode error.
    logic [31:0] mem [0:15];
    logic [31:0] s_rdata;
    logic [7:0]  s_code;
    int n_checks = 0;
    int n_fail   = 0;
    int n_xact   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic check_req(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [3:0] id);
        check("req_valid", bus.req_valid, 1);
        check("req_op", bus.req_op, op);
        check("req_addr", bus.req_addr, addr);
        check("req_wdata", bus.req_wdata, wdata);
        check("req_wstrb", bus.req_wstrb, strb);
        check("req_id", bus.req_id, id);
        check("req_size", bus.req_size, 2);
        check("req_attr", bus.req_attr, 0);
    endtask

    task automatic accept_req(input int stall, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] id);
        for (int i = 0; i < stall; i++) begin
            check_req(op, addr, wdata, strb, id);
            tick();
        end
        check_req(op, addr, wdata, strb, id);
        bus.req_ready = 1'b1;
        if (addr < 32'h40) begin
            if (op == WR) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
                end
                s_rdata = 32'h0;
            end else begin
                s_rdata = mem[addr[5:2]];
            end
            s_code = OK;
        end else begin
            s_rdata = 32'h0;
            s_code  = DEC;
        end
        tick();
        bus.req_ready = 1'b0;
        check("req_valid_after_fire", bus.req_valid, 0);
    endtask

    task automatic drive_rsp(input logic [3:0] id, input logic [31:0] rdata, input logic [7:0] code);
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id;
        bus.rsp_rdata = rdata;
        bus.rsp_code  = code;
        check("rsp_ready", bus.rsp_ready, 1);
        tick();
        bus.rsp_valid = 1'b0;
    endtask

    task automatic give_rsp(input int delay, input logic [3:0] id);
        for (int i = 0; i < delay; i++) begin
            check("res_valid_wait", res_valid, 0);
            tick();
        end
        drive_rsp(id, s_rdata, s_code);
        check("res_valid_rise", res_valid, 1);
    endtask

    task automatic take_res(input int stall, input logic [31:0] rdata, input logic [7:0] code,
                            input logic id_err, input logic tmo);
        for (int i = 0; i <= stall; i++) begin
            check("res_valid", res_valid, 1);
            check("res_rdata", res_rdata, rdata);
            check("res_code", res_code, code);
            check("res_id_err", res_id_err, id_err);
            check("res_timeout", res_timeout, tmo);
            check("cmd_ready_result", cmd_ready, 0);
            check("rsp_ready_result", bus.rsp_ready, 0);
            if (i < stall) tick();
        end
        $display("xact %0d: rdata=0x%08h code=0x%02h id_err=%0d timeout=%0d",
                 n_xact, res_rdata, res_code, res_id_err, res_timeout);
        n_xact++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_after_fire", res_valid, 0);
        check("cmd_ready_after_res", cmd_ready, 1);
    endtask

    task automatic run(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [3:0] id, input int req_stall,
                       input int rsp_delay, input int res_stall, input logic [3:0] rsp_id,
                       input logic [31:0] exp_rdata, input logic [7:0] exp_code, input logic exp_id_err);
        send_cmd(op, addr, wdata, strb);
        accept_req(req_stall, op, addr, wdata, strb, id);
        give_rsp(rsp_delay, rsp_id);
        take_res(res_stall, exp_rdata, exp_code, exp_id_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        res_ready = 1'b0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_id = '0;
        bus.rsp_rdata = '0; bus.rsp_code = '0;
        s_rdata = '0; s_code = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_rsp_ready", bus.rsp_ready, 1);
        check("rst_res_rdata", res_rdata, 0);
        check("rst_res_code", res_code, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_stale_cnt", stale_cnt, 0);

        // Write, then read back the same word.
        run(WR, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, 0, 0, 0, 4'd0, 32'h0, OK, 1'b0);
        run(RD, 32'h10, 32'h0, 4'h0, 4'd1, 0, 0, 0, 4'd1, 32'hDEADBEEF, OK, 1'b0);

        // After a reset, 17 reads must carry IDs 0..15 and then 0.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            run(RD, 32'h10, 32'h0, 4'h0, ID_W'(i), 0, 0, 0, ID_W'(i), 32'hDEADBEEF, OK, 1'b0);
        end

        // Backpressure on the request and result channels, with a partial-strobe write.
        run(WR, 32'h20, 32'h12345678, 4'h5, 4'd1, 5, 2, 3, 4'd1, 32'h0, OK, 1'b0);
        run(RD, 32'h20, 32'h0, 4'h0, 4'd2, 5, 0, 3, 4'd2, 32'h00340078, OK, 1'b0);

        // A decode error from the slave, then a response with a mismatched ID.
        run(RD, 32'h100, 32'h0, 4'h0, 4'd3, 0, 0, 0, 4'd3, 32'h0, DEC, 1'b0);
        run(RD, 32'h10, 32'h0, 4'h0, 4'd4, 0, 1, 0, 4'd5, 32'hDEADBEEF, OK, 1'b1);

        // Timeout: the result must appear exactly 8 cycles after the request handshake.
        send_cmd(RD, 32'h10, 32'h0, 4'h0);
        accept_req(0, RD, 32'h10, 32'h0, 4'h0, 4'd5);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("res_valid_pre_timeout", res_valid, 0);
        end
        tick();
        check("res_valid_timeout", res_valid, 1);
        take_res(0, 32'h0, 8'h0, 1'b0, 1'b1);
        check("stale_before_late", stale_cnt, 0);
        repeat (11) tick();
        drive_rsp(4'd5, 32'hDEADBEEF, OK);
        check("stale_after_late", stale_cnt, 1);
        check("res_valid_after_late", res_valid, 0);
        run(RD, 32'h10, 32'h0, 4'h0, 4'd6, 0, 0, 0, 4'd6, 32'hDEADBEEF, OK, 1'b0);

        // Reset while waiting for a response.
        send_cmd(RD, 32'h10, 32'h0, 4'h0);
        accept_req(0, RD, 32'h10, 32'h0, 4'h0, 4'd7);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_req_valid", bus.req_valid, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_res_rdata", res_rdata, 0);
        check("midrst_stale", stale_cnt, 0);
        drive_rsp(4'd7, 32'hDEADBEEF, OK);
        check("midrst_stale_late", stale_cnt, 1);
        check("midrst_res_valid_late", res_valid, 0);
        run(RD, 32'h10, 32'h0, 4'h0, 4'd0, 0, 0, 0, 4'd0, 32'hDEADBEEF, OK, 1'b0);

        // Stale counter saturation: hold rsp_valid high while idle.
        bus.rsp_valid = 1'b1;
        repeat (253) tick();
        check("stale_254", stale_cnt, 254);
        tick();
        check("stale_255", stale_cnt, 255);
        tick();
        check("stale_saturated", stale_cnt, 255);
        bus.rsp_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
